retire_commit: RTL and testbench

Back end of the ROB retire interface in the Tomasulo MIPS core. Consumes one retired instruction per cycle and turns it into architectural side effects: register-file write, store-buffer commit, branch-mispredict redirect. It also owns the free list of 32 ROB tags, handing tags to dispatch (`new_rd_tag`) and reclaiming them at retire, which closes the tag loop.

---
 rtl/rob_pkg.sv | 30 +++
 rtl/tag_free_list.sv | 58 +++++
 rtl/retire_commit.sv | 128 ++++++++++++
 tb/tb_retire_commit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared definitions for the ROB retire back end: widths, retired-instruction
// classes and the retire/commit FSM states.
package rob_pkg;

  localparam int TAG_W    = 5;
  localparam int NUM_TAGS = 32;
  localparam int DATA_W   = 32;

  typedef enum logic [1:0] {
    INST_REG    = 2'b00,
    INST_BRANCH = 2'b01,
    INST_STORE  = 2'b10
  } inst_t;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // Branch wins over store so a malformed retire still resolves control flow.
  function automatic inst_t classify(input logic is_branch, input logic is_store);
    if (is_branch)
      return INST_BRANCH;
    else if (is_store)
      return INST_STORE;
    else
      return INST_REG;
  endfunction

endpackage

// File: rtl/tag_free_list.sv
// Circular free list of ROB tags. Pointers carry a wrap bit so a full list
// (count == NUM_TAGS) is distinguishable from an empty one.
module tag_free_list
  import rob_pkg::*;
#(
  parameter int TAG_W    = rob_pkg::TAG_W,
  parameter int NUM_TAGS = rob_pkg::NUM_TAGS
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             init,
  input  logic             push,
  input  logic [TAG_W-1:0] push_tag,
  input  logic             pop,
  output logic [TAG_W-1:0] head_tag,
  output logic [TAG_W:0]   count,
  output logic             err_double_free
);

  localparam logic [TAG_W:0] FULL = (TAG_W+1)'(NUM_TAGS);

  logic [TAG_W-1:0] mem [NUM_TAGS];
  logic [TAG_W:0]   head;
  logic [TAG_W:0]   tail;
  logic             full;
  logic             do_pop;
  logic             do_push;

  assign count    = tail - head;
  assign full     = (count == FULL);
  assign head_tag = mem[head[TAG_W-1:0]];
  assign do_pop   = pop && (count != '0);
  // A pop in the same cycle frees the slot, so a push onto a full list is legal then.
  assign do_push  = push && (!full || do_pop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_TAGS; i++) mem[i] <= TAG_W'(i);
      head            <= '0;
      tail            <= FULL;
      err_double_free <= 1'b0;
    end else if (init) begin
      for (int i = 0; i < NUM_TAGS; i++) mem[i] <= TAG_W'(i);
      head <= '0;
      tail <= FULL;
    end else begin
      if (do_pop)
        head <= head + 1'b1;
      if (do_push) begin
        mem[tail[TAG_W-1:0]] <= push_tag;
        tail                 <= tail + 1'b1;
      end
      if (push && full && !do_pop)
        err_double_free <= 1'b1;
    end
  end

endmodule

// File: rtl/retire_commit.sv
// Retire back end: turns each retired instruction into an ARF write, store
// commit or redirect, recycles its ROB tag, and stalls dispatch after a mispredict.
module retire_commit
  import rob_pkg::*;
#(
  parameter int TAG_W           = rob_pkg::TAG_W,
  parameter int NUM_TAGS        = rob_pkg::NUM_TAGS,
  parameter int DATA_W          = rob_pkg::DATA_W,
  parameter int REDIRECT_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              Retire_valid,
  input  logic [TAG_W-1:0]  Retire_rd_tag,
  input  logic [4:0]        Retire_rd_reg,
  input  logic [DATA_W-1:0] Retire_data,
  input  logic [DATA_W-1:0] Retire_pc,
  input  logic              Retire_branch,
  input  logic              Retire_branch_taken,
  input  logic              Retire_store_ready,
  input  logic              Alloc_req,
  output logic [TAG_W-1:0]  Alloc_tag,
  output logic              Alloc_valid,
  output logic              Arf_wen,
  output logic [4:0]        Arf_waddr,
  output logic [DATA_W-1:0] Arf_wdata,
  output logic              Store_commit,
  output logic [TAG_W-1:0]  Store_commit_tag,
  output logic              Redirect_valid,
  output logic [DATA_W-1:0] Redirect_pc,
  output logic              Stall_dispatch,
  output logic              Err_double_free
);

  localparam int CNT_W = (REDIRECT_CYCLES > 1) ? $clog2(REDIRECT_CYCLES) : 1;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] drain_cnt;
  logic [CNT_W-1:0] cnt_next;
  inst_t            inst;
  logic             retire_ok;
  logic             redirect;
  logic             arf_write;
  logic             store_write;
  logic [TAG_W:0]   free_count;

  // Retires seen while draining belong to the flushed window and are dropped.
  assign retire_ok   = Retire_valid && (state == RUN);
  assign inst        = classify(Retire_branch, Retire_store_ready);
  assign redirect    = retire_ok && (inst == INST_BRANCH) && Retire_branch_taken;
  assign arf_write   = retire_ok && (inst == INST_REG) && (Retire_rd_reg != 5'd0);
  assign store_write = retire_ok && (inst == INST_STORE);

  assign Stall_dispatch = (state == DRAIN);
  assign Alloc_valid    = (free_count != '0) && !Stall_dispatch;

  tag_free_list #(
    .TAG_W    (TAG_W),
    .NUM_TAGS (NUM_TAGS)
  ) u_free_list (
    .clock           (clock),
    .reset           (reset),
    .init            (redirect),
    .push            (retire_ok),
    .push_tag        (Retire_rd_tag),
    .pop             (Alloc_req && Alloc_valid),
    .head_tag        (Alloc_tag),
    .count           (free_count),
    .err_double_free (Err_double_free)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      drain_cnt <= '0;
    end else begin
      state     <= state_next;
      drain_cnt <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = drain_cnt;
    case (state)
      RUN: begin
        if (redirect) begin
          state_next = DRAIN;
          cnt_next   = CNT_W'(REDIRECT_CYCLES - 1);
        end
      end
      DRAIN: begin
        if (drain_cnt == '0)
          state_next = RUN;
        else
          cnt_next = drain_cnt - 1'b1;
      end
      default: state_next = RUN;
    endcase
  end

  // Strobes pulse for one cycle; payload registers hold their last value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      Arf_wen          <= 1'b0;
      Arf_waddr        <= '0;
      Arf_wdata        <= '0;
      Store_commit     <= 1'b0;
      Store_commit_tag <= '0;
      Redirect_valid   <= 1'b0;
      Redirect_pc      <= '0;
    end else begin
      Arf_wen        <= arf_write;
      Store_commit   <= store_write;
      Redirect_valid <= redirect;
      if (arf_write) begin
        Arf_waddr <= Retire_rd_reg;
        Arf_wdata <= Retire_data;
      end
      if (store_write)
        Store_commit_tag <= Retire_rd_tag;
      if (redirect)
        Redirect_pc <= Retire_pc;
    end
  end

endmodule

// File: tb/tb_retire_commit.sv
// Scoreboard bench for retire_commit: a queue-based free-list model predicts each
// cycle's outputs, and an independent monitor compares them on the falling edge.
module tb_retire_commit;

  localparam int RC = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        Retire_valid = 1'b0;
  logic [4:0]  Retire_rd_tag = '0;
  logic [4:0]  Retire_rd_reg = '0;
  logic [31:0] Retire_data = '0;
  logic [31:0] Retire_pc = '0;
  logic        Retire_branch = 1'b0;
  logic        Retire_branch_taken = 1'b0;
  logic        Retire_store_ready = 1'b0;
  logic        Alloc_req = 1'b0;
  logic [4:0]  Alloc_tag;
  logic        Alloc_valid;
  logic        Arf_wen;
  logic [4:0]  Arf_waddr;
  logic [31:0] Arf_wdata;
  logic        Store_commit;
  logic [4:0]  Store_commit_tag;
  logic        Redirect_valid;
  logic [31:0] Redirect_pc;
  logic        Stall_dispatch;
  logic        Err_double_free;

  retire_commit #(.REDIRECT_CYCLES(RC)) dut (
    .clock               (clock),
    .reset               (reset),
    .Retire_valid        (Retire_valid),
    .Retire_rd_tag       (Retire_rd_tag),
    .Retire_rd_reg       (Retire_rd_reg),
    .Retire_data         (Retire_data),
    .Retire_pc           (Retire_pc),
    .Retire_branch       (Retire_branch),
    .Retire_branch_taken (Retire_branch_taken),
    .Retire_store_ready  (Retire_store_ready),
    .Alloc_req           (Alloc_req),
    .Alloc_tag           (Alloc_tag),
    .Alloc_valid         (Alloc_valid),
    .Arf_wen             (Arf_wen),
    .Arf_waddr           (Arf_waddr),
    .Arf_wdata           (Arf_wdata),
    .Store_commit        (Store_commit),
    .Store_commit_tag    (Store_commit_tag),
    .Redirect_valid      (Redirect_valid),
    .Redirect_pc         (Redirect_pc),
    .Stall_dispatch      (Stall_dispatch),
    .Err_double_free     (Err_double_free)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        av;
    logic        tag_known;
    logic [4:0]  atag;
    logic        arf;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        sc;
    logic [4:0]  stag;
    logic        rv;
    logic [31:0] pc;
    logic        stall;
    logic        err;
    logic        zero_fields;
  } exp_t;

  exp_t exp_q[$];
  int   free_q[$];
  bit   m_err;
  int   drain_left;
  int   checks = 0;
  int   errors = 0;

  function automatic void modelReset();
    free_q = {};
    for (int i = 0; i < 32; i++) free_q.push_back(i);
    m_err      = 1'b0;
    drain_left = 0;
  endfunction

  function automatic exp_t stateSnapshot();
    exp_t e;
    e = '{default: '0};
    e.av        = (free_q.size() != 0) && (drain_left == 0);
    e.tag_known = (free_q.size() != 0);
    e.atag      = e.tag_known ? 5'(free_q[0]) : 5'd0;
    e.stall     = (drain_left != 0);
    e.err       = m_err;
    return e;
  endfunction

  // One clock of stimulus; the model advances with the same inputs and the
  // predicted post-edge outputs are queued for the monitor.
  task automatic applyStimulus(input bit valid, input int tag, input int rd,
                               input logic [31:0] data, input logic [31:0] pc,
                               input bit br, input bit taken, input bit st,
                               input bit alloc);
    bit   ok;
    bit   pop;
    exp_t e;
    bit   arf;
    bit   sc;
    bit   rv;
    Retire_valid        = valid;
    Retire_rd_tag       = 5'(tag);
    Retire_rd_reg       = 5'(rd);
    Retire_data         = data;
    Retire_pc           = pc;
    Retire_branch       = br;
    Retire_branch_taken = taken;
    Retire_store_ready  = st;
    Alloc_req           = alloc;

    ok  = valid && (drain_left == 0);
    pop = alloc && (free_q.size() != 0) && (drain_left == 0);
    rv  = ok && br && taken;
    sc  = ok && !br && st;
    arf = ok && !br && !st && (rd != 0);
    if (rv) begin
      free_q = {};
      for (int i = 0; i < 32; i++) free_q.push_back(i);
      drain_left = RC;
    end else begin
      if (drain_left > 0) drain_left--;
      if (pop) void'(free_q.pop_front());
      if (ok) begin
        if (free_q.size() < 32) free_q.push_back(tag);
        else m_err = 1'b1;
      end
    end
    e       = stateSnapshot();
    e.arf   = arf;
    e.waddr = 5'(rd);
    e.wdata = data;
    e.sc    = sc;
    e.stag  = 5'(tag);
    e.rv    = rv;
    e.pc    = pc;

    @(posedge clock);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic doReset();
    exp_t e;
    @(negedge clock);
    #1;
    reset               = 1'b1;
    Retire_valid        = 1'b0;
    Retire_branch       = 1'b0;
    Retire_branch_taken = 1'b0;
    Retire_store_ready  = 1'b0;
    Alloc_req           = 1'b0;
    modelReset();
    e = stateSnapshot();
    e.zero_fields = 1'b1;
    @(posedge clock);
    exp_q.push_back(e);
    #1;
    reset = 1'b0;
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmp("Alloc_valid", 32'(Alloc_valid), 32'(e.av));
    if (e.tag_known) cmp("Alloc_tag", 32'(Alloc_tag), 32'(e.atag));
    cmp("Arf_wen", 32'(Arf_wen), 32'(e.arf));
    cmp("Store_commit", 32'(Store_commit), 32'(e.sc));
    cmp("Redirect_valid", 32'(Redirect_valid), 32'(e.rv));
    cmp("Stall_dispatch", 32'(Stall_dispatch), 32'(e.stall));
    cmp("Err_double_free", 32'(Err_double_free), 32'(e.err));
    if (e.arf) begin
      cmp("Arf_waddr", 32'(Arf_waddr), 32'(e.waddr));
      cmp("Arf_wdata", Arf_wdata, e.wdata);
    end
    if (e.sc) cmp("Store_commit_tag", 32'(Store_commit_tag), 32'(e.stag));
    if (e.rv) cmp("Redirect_pc", Redirect_pc, e.pc);
    if (e.zero_fields) begin
      cmp("reset Arf_waddr", 32'(Arf_waddr), 32'd0);
      cmp("reset Arf_wdata", Arf_wdata, 32'd0);
      cmp("reset Store_commit_tag", 32'(Store_commit_tag), 32'd0);
      cmp("reset Redirect_pc", Redirect_pc, 32'd0);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin : watchdog
    #200000;
    errors++;
    checks++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : stimulus
    int r;
    modelReset();
    doReset();

    // Drain the whole list, then request once more while empty.
    repeat (32) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);

    applyStimulus(1, 7, 0, 32'h1234, 0, 0, 0, 0, 0);
    applyStimulus(1, 4, 3, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    applyStimulus(1, 9, 6, 32'h5555, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Mispredict, then retires and alloc requests during the stall are dropped.
    applyStimulus(1, 11, 0, 0, 32'h400, 1, 1, 0, 1);
    applyStimulus(1, 12, 5, 32'hAAAA, 0, 0, 0, 0, 1);
    applyStimulus(1, 13, 6, 32'hBBBB, 0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(1, 5, 9, 32'h77, 0, 1, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 3, 0, 0, 0, 0, 0, 0, 0);
    repeat (33) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);

    applyStimulus(1, 2, 0, 0, 32'h800, 1, 1, 0, 0);
    doReset();

    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(19);
      applyStimulus(($urandom_range(3) != 0), $urandom_range(31), $urandom_range(31),
                    $urandom, $urandom, (r < 3), (r == 0), (r >= 3 && r < 7),
                    $urandom_range(1));
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    repeat (3) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
